// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one sequential multiplier
// between two requesters, with a WAIT timeout that aborts the operation.
//
// Ports:
//   clk, reset (async, active-low)
//   req0/req1, a0/b0/a1/b1   : requester levels and operands
//   done0/done1, err0/err1   : completion / timeout pulses
//   res0/res1                : registered products per requester
//   busy                     : FSM not idle
//   mul_a/mul_b/mul_start    : multiplier command
//   mul_product/mul_valid    : multiplier response
module mult_arbiter #(
  parameter int TIMEOUT = 32,
  parameter int W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           done0,
  output logic           done1,
  output logic           err0,
  output logic           err1,
  output logic [2*W-1:0] res0,
  output logic [2*W-1:0] res1,
  output logic           busy,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_start,
  input  logic [2*W-1:0] mul_product,
  input  logic           mul_valid
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       owner;
  logic       last;
  logic       err_q;
  logic [7:0] cnt;
  logic       grant;
  logic       any_req;
  logic       timeout;

  assign any_req = req0 | req1;

  // On a tie, serve whoever was not served last.
  assign grant = (req0 && req1) ? ~last : req1;

  assign timeout = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (any_req) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (mul_valid || timeout) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= 1'b0;
      last  <= 1'b1;
      err_q <= 1'b0;
      cnt   <= 8'd0;
      res0  <= '0;
      res1  <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant;
            mul_a <= grant ? a1 : a0;
            mul_b <= grant ? b1 : b0;
          end
        end
        ISSUE: begin
          cnt   <= 8'd0;
          err_q <= 1'b0;
        end
        WAIT: begin
          // A valid on the timeout edge still counts as success.
          if (mul_valid) begin
            if (owner) res1 <= mul_product;
            else       res0 <= mul_product;
          end else if (timeout) begin
            if (owner) res1 <= '0;
            else       res0 <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: last <= owner;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mul_start = (state == ISSUE);
  assign done0     = (state == DONE) && !owner;
  assign done1     = (state == DONE) && owner;
  assign err0      = done0 && err_q;
  assign err1      = done1 && err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed bench for mult_arbiter with a transaction
// model checked every cycle plus literal expectations per scenario.
module tb_mult_arbiter;

  localparam int W  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req0 = 1'b0;
  logic           req1 = 1'b0;
  logic [W-1:0]   a0 = '0;
  logic [W-1:0]   b0 = '0;
  logic [W-1:0]   a1 = '0;
  logic [W-1:0]   b1 = '0;
  logic           done0, done1, err0, err1;
  logic [2*W-1:0] res0, res1;
  logic           busy, mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_product = '0;
  logic           mul_valid;
  logic           mv = 1'b0;
  logic           spur = 1'b0;

  assign mul_valid = mv | spur;

  mult_arbiter #(.TIMEOUT(TO), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .res0(res0), .res1(res1),
    .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start),
    .mul_product(mul_product),
    .mul_valid(mul_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Multiplier stand-in: answers dly cycles after the start cycle;
  // dly < 0 means it never answers.
  int dly = 1;
  int mcnt = -1;
  always @(posedge clk) begin
    #2;
    mv = 1'b0;
    if (!reset) begin
      mcnt = -1;
    end else if (mul_start) begin
      mcnt = dly;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mv = 1'b1;
        mul_product = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      end
    end
  end

  int starts = 0;
  int dones = 0;
  always @(negedge clk) begin
    if (mul_start) starts++;
    if (done0 || done1) dones++;
  end

  // Transaction model: an operation is granted, spends one cycle
  // issuing, waits up to TO cycles, then reports for one cycle.
  bit             m_act, m_fin, m_err, m_own;
  bit             m_last;
  int             m_age, m_waits;
  logic [2*W-1:0] m_res [2];
  logic [W-1:0]   m_ma, m_mb;

  function automatic void m_reset();
    m_act = 0; m_fin = 0; m_err = 0; m_own = 0;
    m_last = 1; m_age = 0; m_waits = 0;
    m_res[0] = '0; m_res[1] = '0;
    m_ma = '0; m_mb = '0;
  endfunction

  function automatic void m_step();
    if (!m_act) begin
      if (req0 || req1) begin
        m_own = (req0 && req1) ? !m_last : req1;
        m_ma = m_own ? a1 : a0;
        m_mb = m_own ? b1 : b0;
        m_act = 1; m_age = 0; m_fin = 0; m_err = 0;
      end
    end else if (m_fin) begin
      m_act = 0; m_fin = 0;
      m_last = m_own;
    end else if (m_age == 0) begin
      m_age = 1; m_waits = 0;
    end else begin
      m_waits++;
      if (mul_valid) begin
        m_res[m_own] = mul_product;
        m_fin = 1;
      end else if (m_waits == TO) begin
        m_res[m_own] = '0;
        m_fin = 1; m_err = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) m_reset();
    chk("busy", busy, m_act);
    chk("mul_start", mul_start, m_act && !m_fin && m_age == 0);
    chk("done0", done0, m_fin && !m_own);
    chk("done1", done1, m_fin && m_own);
    chk("err0", err0, m_fin && m_err && !m_own);
    chk("err1", err1, m_fin && m_err && m_own);
    chk("res0", res0, m_res[0]);
    chk("res1", res1, m_res[1]);
    chk("mul_a", mul_a, m_ma);
    chk("mul_b", mul_b, m_mb);
    chk("done_excl", done0 && done1, 0);
    if (reset) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit which, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (which ? done1 : done0) return;
    end
    total++;
    bad++;
    $display("FAIL wait_done%0d: got no pulse want pulse", which);
  endtask

  int n, s0, d0;

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_res0", res0, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mula", mul_a, 0);
    reset = 1'b1;
    tick();

    // Tie after reset: 0 first, then alternate.
    dly = 2;
    a0 = 4'd2; b0 = 4'd7; a1 = 4'd4; b1 = 4'd4;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(0, n);
    chk("tie_res0", res0, 14);
    chk("tie_done1", done1, 0);
    wait_done(1, n);
    chk("tie_res1", res1, 16);
    wait_done(0, n);
    chk("tie_again0", done0, 1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Single request, answer three cycles after start.
    dly = 3;
    a0 = 4'd3; b0 = 4'd5; req0 = 1'b1;
    s0 = starts;
    wait_done(0, n);
    chk("t1_res0", res0, 15);
    chk("t1_err0", err0, 0);
    chk("t1_starts", starts - s0, 1);
    chk("t1_lat", n, 6);
    tick();
    req0 = 1'b0;
    tick();
    chk("t1_busy", busy, 0);

    // Minimum latency.
    dly = 1;
    a1 = 4'd2; b1 = 4'd3; req1 = 1'b1;
    wait_done(1, n);
    chk("lat_min", n, 4);
    chk("lat_res1", res1, 6);
    tick();
    req1 = 1'b0;
    tick();

    // Timeout.
    dly = -1;
    a1 = 4'd5; b1 = 4'd5; req1 = 1'b1;
    wait_done(1, n);
    chk("to_err1", err1, 1);
    chk("to_res1", res1, 0);
    chk("to_lat", n, 11);
    tick();
    req1 = 1'b0;
    tick();
    chk("to_busy", busy, 0);

    // Valid on the last timeout cycle wins.
    dly = TO;
    a0 = 4'd6; b0 = 4'd7; req0 = 1'b1;
    wait_done(0, n);
    chk("edge_err0", err0, 0);
    chk("edge_res0", res0, 42);
    chk("edge_lat", n, 11);
    tick();
    req0 = 1'b0;
    tick();

    // Reset in the middle of WAIT.
    dly = -1;
    a1 = 4'd7; b1 = 4'd7; req1 = 1'b1;
    repeat (4) tick();
    chk("rw_busy_pre", busy, 1);
    d0 = dones;
    reset = 1'b0;
    req1 = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_res0", res0, 0);
    chk("rw_mula", mul_a, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rw_nodone", dones - d0, 0);
    dly = 2;
    a1 = 4'd3; b1 = 4'd3; req1 = 1'b1;
    wait_done(1, n);
    chk("rw_res1", res1, 9);
    chk("rw_err1", err1, 0);
    tick();
    req1 = 1'b0;
    tick();

    // Spurious valid in IDLE, then in ISSUE.
    spur = 1'b1;
    repeat (2) tick();
    chk("sp_busy", busy, 0);
    chk("sp_res0", res0, 0);
    chk("sp_res1", res1, 9);
    a0 = 4'd2; b0 = 4'd2; req0 = 1'b1;
    tick();
    chk("sp_issue", mul_start, 1);
    tick();
    spur = 1'b0;
    wait_done(0, n);
    chk("sp_res0b", res0, 4);
    chk("sp_lat", n, 3);
    tick();
    req0 = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
